// File: rtl/sched_ctrl_fsm_if.sv
// Control bundle between sched_ctrl_fsm (master) and the scheduled datapath (slave).
interface sched_ctrl_fsm_if #(
    parameter int CNT_W = 8
) ();
    logic             start;
    logic             busy;
    logic [3:0]       alu1_sel1, alu1_sel2, alu2_sel1, alu2_sel2;
    logic [3:0]       mul1_sel1, mul1_sel2, log1_sel1, log1_sel2;
    logic             alu1_op, alu2_op, mul1_op;
    logic [1:0]       log1_op;
    logic             reg_alu2_en, reg_alu5_en, reg_mul6_en, reg_alu9_en;
    logic             reg_alu12_en, reg_mul13_en, reg_log14_en;
    logic             result_en;
    logic             done_next;
    logic [CNT_W-1:0] run_count;

    modport master (
        input  start,
        output busy,
        output alu1_sel1, alu1_sel2, alu2_sel1, alu2_sel2,
        output mul1_sel1, mul1_sel2, log1_sel1, log1_sel2,
        output alu1_op, alu2_op, mul1_op, log1_op,
        output reg_alu2_en, reg_alu5_en, reg_mul6_en, reg_alu9_en,
        output reg_alu12_en, reg_mul13_en, reg_log14_en,
        output result_en, done_next, run_count
    );

    modport slave (
        output start,
        input  busy,
        input  alu1_sel1, alu1_sel2, alu2_sel1, alu2_sel2,
        input  mul1_sel1, mul1_sel2, log1_sel1, log1_sel2,
        input  alu1_op, alu2_op, mul1_op, log1_op,
        input  reg_alu2_en, reg_alu5_en, reg_mul6_en, reg_alu9_en,
        input  reg_alu12_en, reg_mul13_en, reg_log14_en,
        input  result_en, done_next, run_count
    );
endinterface

// File: rtl/sched_ctrl_fsm.sv
// Five-step Moore schedule controller for the alu1/alu2/mul1/log1 datapath.
// Optional SCHED_STEP_EN adds a `step` input that gates advancement of S1..S5.
module sched_ctrl_fsm #(
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst,
`ifdef SCHED_STEP_EN
    input  logic step,
`endif
    sched_ctrl_fsm_if.master ctl
);

    // Operand select codes: 0..7 = i1..i8, 8..14 = intermediate registers, 15 = zero.
    localparam logic [3:0] SEL_I1     = 4'd0;
    localparam logic [3:0] SEL_I2     = 4'd1;
    localparam logic [3:0] SEL_I3     = 4'd2;
    localparam logic [3:0] SEL_I4     = 4'd3;
    localparam logic [3:0] SEL_I5     = 4'd4;
    localparam logic [3:0] SEL_I6     = 4'd5;
    localparam logic [3:0] SEL_I7     = 4'd6;
    localparam logic [3:0] SEL_I8     = 4'd7;
    localparam logic [3:0] SEL_ALU2   = 4'd8;
    localparam logic [3:0] SEL_ALU5   = 4'd9;
    localparam logic [3:0] SEL_MUL6   = 4'd10;
    localparam logic [3:0] SEL_ALU9   = 4'd11;
    localparam logic [3:0] SEL_ALU12  = 4'd12;
    localparam logic [3:0] SEL_MUL13  = 4'd13;
    localparam logic [3:0] SEL_ZERO   = 4'd15;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        S1   = 3'd1,
        S2   = 3'd2,
        S3   = 3'd3,
        S4   = 3'd4,
        S5   = 3'd5
    } state_t;

    state_t           r_state, w_next;
    logic [CNT_W-1:0] r_run_count;

    logic       w_adv;
    logic       w_busy;
    logic [3:0] w_alu1_sel1, w_alu1_sel2, w_alu2_sel1, w_alu2_sel2;
    logic [3:0] w_mul1_sel1, w_mul1_sel2, w_log1_sel1, w_log1_sel2;
    logic       w_alu1_op, w_alu2_op, w_mul1_op;
    logic [1:0] w_log1_op;
    logic       w_alu2_en, w_alu5_en, w_mul6_en, w_alu9_en;
    logic       w_alu12_en, w_mul13_en, w_log14_en;
    logic       w_result_en, w_done_next;

`ifdef SCHED_STEP_EN
    assign w_adv = step;
`else
    assign w_adv = 1'b1;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_run_count <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S5 && w_adv)
                r_run_count <= r_run_count + 1'b1;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_busy      = 1'b0;
        w_alu1_sel1 = SEL_ZERO;
        w_alu1_sel2 = SEL_ZERO;
        w_alu2_sel1 = SEL_ZERO;
        w_alu2_sel2 = SEL_ZERO;
        w_mul1_sel1 = SEL_ZERO;
        w_mul1_sel2 = SEL_ZERO;
        w_log1_sel1 = SEL_ZERO;
        w_log1_sel2 = SEL_ZERO;
        w_alu1_op   = 1'b0;
        w_alu2_op   = 1'b0;
        w_mul1_op   = 1'b0;
        w_log1_op   = 2'b00;
        w_alu2_en   = 1'b0;
        w_alu5_en   = 1'b0;
        w_mul6_en   = 1'b0;
        w_alu9_en   = 1'b0;
        w_alu12_en  = 1'b0;
        w_mul13_en  = 1'b0;
        w_log14_en  = 1'b0;
        w_result_en = 1'b0;
        w_done_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (ctl.start) w_next = S1;
            end
            S1: begin
                w_busy      = 1'b1;
                w_alu1_sel1 = SEL_I1;
                w_alu1_sel2 = SEL_I2;
                w_alu2_sel1 = SEL_I3;
                w_alu2_sel2 = SEL_I4;
                w_alu2_op   = 1'b1;
                w_mul1_sel1 = SEL_I5;
                w_mul1_sel2 = SEL_I6;
                w_alu2_en   = 1'b1;
                w_alu5_en   = 1'b1;
                w_mul6_en   = 1'b1;
                if (w_adv) w_next = S2;
            end
            S2: begin
                w_busy      = 1'b1;
                w_alu1_sel1 = SEL_ALU2;
                w_alu1_sel2 = SEL_MUL6;
                w_alu2_sel1 = SEL_ALU5;
                w_alu2_sel2 = SEL_I7;
                w_alu2_op   = 1'b1;
                w_alu9_en   = 1'b1;
                w_alu12_en  = 1'b1;
                if (w_adv) w_next = S3;
            end
            S3: begin
                w_busy      = 1'b1;
                w_mul1_sel1 = SEL_ALU9;
                w_mul1_sel2 = SEL_ALU12;
                w_mul13_en  = 1'b1;
                if (w_adv) w_next = S4;
            end
            S4: begin
                w_busy      = 1'b1;
                w_log1_sel1 = SEL_MUL13;
                w_log1_sel2 = SEL_I8;
                w_log1_op   = 2'b10;
                w_log14_en  = 1'b1;
                if (w_adv) w_next = S5;
            end
            S5: begin
                w_busy      = 1'b1;
                w_result_en = 1'b1;
                w_done_next = 1'b1;
                if (w_adv) w_next = ctl.start ? S1 : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Selects/ops always reflect the current step; only the write strobes are held off.
    assign ctl.busy         = w_busy;
    assign ctl.alu1_sel1    = w_alu1_sel1;
    assign ctl.alu1_sel2    = w_alu1_sel2;
    assign ctl.alu2_sel1    = w_alu2_sel1;
    assign ctl.alu2_sel2    = w_alu2_sel2;
    assign ctl.mul1_sel1    = w_mul1_sel1;
    assign ctl.mul1_sel2    = w_mul1_sel2;
    assign ctl.log1_sel1    = w_log1_sel1;
    assign ctl.log1_sel2    = w_log1_sel2;
    assign ctl.alu1_op      = w_alu1_op;
    assign ctl.alu2_op      = w_alu2_op;
    assign ctl.mul1_op      = w_mul1_op;
    assign ctl.log1_op      = w_log1_op;
    assign ctl.reg_alu2_en  = w_alu2_en   & w_adv;
    assign ctl.reg_alu5_en  = w_alu5_en   & w_adv;
    assign ctl.reg_mul6_en  = w_mul6_en   & w_adv;
    assign ctl.reg_alu9_en  = w_alu9_en   & w_adv;
    assign ctl.reg_alu12_en = w_alu12_en  & w_adv;
    assign ctl.reg_mul13_en = w_mul13_en  & w_adv;
    assign ctl.reg_log14_en = w_log14_en  & w_adv;
    assign ctl.result_en    = w_result_en & w_adv;
    assign ctl.done_next    = w_done_next & w_adv;
    assign ctl.run_count    = r_run_count;

endmodule

// File: tb/tb_sched_ctrl_fsm.sv
// Directed bench: drives sched_ctrl_fsm into a small datapath model and checks results.
module tb_sched_ctrl_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
`ifdef SCHED_STEP_EN
    logic step = 1'b1;
`endif
    always #5 clk = ~clk;

    sched_ctrl_fsm_if #(.CNT_W(8)) bus ();
    sched_ctrl_fsm_if #(.CNT_W(2)) bus2 ();

    sched_ctrl_fsm #(.CNT_W(8)) u_dut (
        .clk (clk),
        .rst (rst),
`ifdef SCHED_STEP_EN
        .step(step),
`endif
        .ctl (bus)
    );

    sched_ctrl_fsm #(.CNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
`ifdef SCHED_STEP_EN
        .step(step),
`endif
        .ctl (bus2)
    );

    int n_cmp = 0;
    int n_err = 0;
    int exp_runs = 0;

    logic [31:0] in_v [1:8];
    logic [31:0] m_alu2, m_alu5, m_mul6, m_alu9, m_alu12, m_mul13, m_log14, m_result;
    logic        m_done;

    function automatic logic [31:0] pick(input logic [3:0] s);
        case (s)
            4'd0:  return in_v[1];
            4'd1:  return in_v[2];
            4'd2:  return in_v[3];
            4'd3:  return in_v[4];
            4'd4:  return in_v[5];
            4'd5:  return in_v[6];
            4'd6:  return in_v[7];
            4'd7:  return in_v[8];
            4'd8:  return m_alu2;
            4'd9:  return m_alu5;
            4'd10: return m_mul6;
            4'd11: return m_alu9;
            4'd12: return m_alu12;
            4'd13: return m_mul13;
            4'd14: return m_log14;
            default: return 32'd0;
        endcase
    endfunction

    logic [31:0] a1, a2, mu, lg, ma, mb, la, lb;
    always_comb begin
        a1 = bus.alu1_op ? pick(bus.alu1_sel1) - pick(bus.alu1_sel2)
                         : pick(bus.alu1_sel1) + pick(bus.alu1_sel2);
        a2 = bus.alu2_op ? pick(bus.alu2_sel1) - pick(bus.alu2_sel2)
                         : pick(bus.alu2_sel1) + pick(bus.alu2_sel2);
        ma = pick(bus.mul1_sel1);
        mb = pick(bus.mul1_sel2);
        mu = bus.mul1_op ? ((mb == 32'd0) ? 32'd0 : ma / mb) : ma * mb;
        la = pick(bus.log1_sel1);
        lb = pick(bus.log1_sel2);
        case (bus.log1_op)
            2'b00:   lg = la & lb;
            2'b01:   lg = la | lb;
            2'b10:   lg = la ^ lb;
            default: lg = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_alu2 <= '0; m_alu5 <= '0; m_mul6 <= '0; m_alu9 <= '0;
            m_alu12 <= '0; m_mul13 <= '0; m_log14 <= '0; m_result <= '0;
            m_done <= 1'b0;
        end else begin
            if (bus.reg_alu2_en)  m_alu2  <= a1;
            if (bus.reg_alu9_en)  m_alu9  <= a1;
            if (bus.reg_alu5_en)  m_alu5  <= a2;
            if (bus.reg_alu12_en) m_alu12 <= a2;
            if (bus.reg_mul6_en)  m_mul6  <= mu;
            if (bus.reg_mul13_en) m_mul13 <= mu;
            if (bus.reg_log14_en) m_log14 <= lg;
            if (bus.result_en)    m_result <= m_log14;
            m_done <= bus.done_next;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int unsigned a, b, c, d, e, f, g, h);
        in_v[1] = a; in_v[2] = b; in_v[3] = c; in_v[4] = d;
        in_v[5] = e; in_v[6] = f; in_v[7] = g; in_v[8] = h;
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        bus2.start = 1'b0;
        set_in(0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        tick();
        tick();
        n_cmp++;
        if ({bus.alu1_sel1, bus.alu1_sel2, bus.alu2_sel1, bus.alu2_sel2,
             bus.mul1_sel1, bus.mul1_sel2, bus.log1_sel1, bus.log1_sel2} !== 32'hFFFF_FFFF) begin
            n_err++;
            $display("FAIL reset_selects: got %h want ffffffff",
                     {bus.alu1_sel1, bus.alu1_sel2, bus.alu2_sel1, bus.alu2_sel2,
                      bus.mul1_sel1, bus.mul1_sel2, bus.log1_sel1, bus.log1_sel2});
        end
        n_cmp++;
        if ({bus.alu1_op, bus.alu2_op, bus.mul1_op, bus.log1_op, bus.reg_alu2_en,
             bus.reg_alu5_en, bus.reg_mul6_en, bus.reg_alu9_en, bus.reg_alu12_en,
             bus.reg_mul13_en, bus.reg_log14_en, bus.result_en, bus.done_next, bus.busy} !== 15'd0) begin
            n_err++;
            $display("FAIL reset_ctrl: ops/enables/busy not all zero");
        end
        n_cmp++;
        if (bus.run_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_run_count: got %0d want 0", bus.run_count);
        end
        rst = 1'b0;
        exp_runs = 0;
        tick();
        n_cmp++;
        if (bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_single(input int unsigned e2, e5, e6, e9, e12, e13, e14, eres);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 5; c++) begin
            n_cmp++;
            if (bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL single_busy_S%0d: got %b want 1", c + 1, bus.busy);
            end
            if (c < 4) tick();
        end
        n_cmp++;
        if ({bus.result_en, bus.done_next} !== 2'b11) begin
            n_err++;
            $display("FAIL s5_strobes: got %b want 11", {bus.result_en, bus.done_next});
        end
        tick();
        exp_runs++;
        n_cmp++;
        if ({m_alu2, m_alu5, m_mul6, m_alu9} !== {e2[31:0], e5[31:0], e6[31:0], e9[31:0]}) begin
            n_err++;
            $display("FAIL regs_a: got %0d %0d %0d %0d want %0d %0d %0d %0d",
                     m_alu2, m_alu5, m_mul6, m_alu9, e2, e5, e6, e9);
        end
        n_cmp++;
        if ({m_alu12, m_mul13, m_log14} !== {e12[31:0], e13[31:0], e14[31:0]}) begin
            n_err++;
            $display("FAIL regs_b: got %0d %0d %0d want %0d %0d %0d",
                     m_alu12, m_mul13, m_log14, e12, e13, e14);
        end
        n_cmp++;
        if (m_result !== eres[31:0] || m_done !== 1'b1 || bus.busy !== 1'b0) begin
            n_err++;
            $display("FAIL result: got %0d done=%b busy=%b want %0d done=1 busy=0",
                     m_result, m_done, bus.busy, eres);
        end
        n_cmp++;
        if (bus.run_count !== 8'(exp_runs)) begin
            n_err++;
            $display("FAIL run_count: got %0d want %0d", bus.run_count, exp_runs);
        end
        tick();
        n_cmp++;
        if (m_done !== 1'b0) begin
            n_err++;
            $display("FAIL done_width: got %b want 0", m_done);
        end
    endtask

    task automatic test_back_to_back();
        set_in(3, 4, 10, 2, 5, 6, 7, 5);
        bus.start = 1'b1;
        tick();
        for (int c = 0; c < 4; c++) begin
            tick();
            n_cmp++;
            if (bus.busy !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_busy_%0d: got %b want 1", c, bus.busy);
            end
            if (c == 0) begin
                n_cmp++;
                if (bus.alu1_sel1 !== 4'd8) begin
                    n_err++;
                    $display("FAIL b2b_start_ignored: alu1_sel1 got %0d want 8", bus.alu1_sel1);
                end
            end
        end
        tick();
        bus.start = 1'b0;
        exp_runs++;
        n_cmp++;
        if (bus.busy !== 1'b1 || m_done !== 1'b1 || m_result !== 32'd32 || bus.alu1_sel1 !== 4'd0) begin
            n_err++;
            $display("FAIL b2b_first: busy=%b done=%b result=%0d sel=%0d want 1 1 32 0",
                     bus.busy, m_done, m_result, bus.alu1_sel1);
        end
        n_cmp++;
        if (bus.run_count !== 8'(exp_runs)) begin
            n_err++;
            $display("FAIL b2b_count1: got %0d want %0d", bus.run_count, exp_runs);
        end
        tick();
        n_cmp++;
        if (m_done !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_done_gap: got %b want 0", m_done);
        end
        repeat (3) tick();
        tick();
        exp_runs++;
        n_cmp++;
        if (bus.busy !== 1'b0 || m_done !== 1'b1 || m_result !== 32'd32 || bus.run_count !== 8'(exp_runs)) begin
            n_err++;
            $display("FAIL b2b_second: busy=%b done=%b result=%0d count=%0d want 0 1 32 %0d",
                     bus.busy, m_done, m_result, bus.run_count, exp_runs);
        end
        tick();
    endtask

    task automatic test_reset_mid_run();
        set_in(3, 4, 10, 2, 5, 6, 7, 5);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.reg_mul13_en !== 1'b1) begin
            n_err++;
            $display("FAIL s3_reached: reg_mul13_en got %b want 1", bus.reg_mul13_en);
        end
        #2;
        rst = 1'b1;
        #1;
        exp_runs = 0;
        n_cmp++;
        if (bus.reg_mul13_en !== 1'b0 || bus.busy !== 1'b0 || bus.done_next !== 1'b0 || bus.run_count !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset: en=%b busy=%b dn=%b count=%0d want 0 0 0 0",
                     bus.reg_mul13_en, bus.busy, bus.done_next, bus.run_count);
        end
        tick();
        tick();
        n_cmp++;
        if (m_done !== 1'b0) begin
            n_err++;
            $display("FAIL reset_no_done: got %b want 0", m_done);
        end
        rst = 1'b0;
        tick();
        set_in(3, 4, 10, 2, 5, 6, 3, 255);
        test_single(7, 8, 30, 37, 5, 185, 70, 70);
    endtask

    task automatic test_count_wrap();
        int unsigned wrap_exp [5];
        wrap_exp = '{1, 2, 3, 0, 1};
        for (int r = 0; r < 5; r++) begin
            bus2.start = 1'b1;
            tick();
            bus2.start = 1'b0;
            repeat (5) tick();
            n_cmp++;
            if (bus2.run_count !== 2'(wrap_exp[r])) begin
                n_err++;
                $display("FAIL wrap_count_%0d: got %0d want %0d", r, bus2.run_count, wrap_exp[r]);
            end
        end
    endtask

`ifdef SCHED_STEP_EN
    task automatic test_step();
        set_in(3, 4, 10, 2, 5, 6, 7, 5);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        step = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (bus.alu1_sel1 !== 4'd8 || bus.reg_alu9_en !== 1'b0 || bus.reg_alu12_en !== 1'b0 ||
                bus.busy !== 1'b1 || m_alu12 !== 32'd5) begin
                n_err++;
                $display("FAIL step_hold_%0d: sel=%0d en9=%b en12=%b busy=%b alu12=%0d want 8 0 0 1 5",
                         c, bus.alu1_sel1, bus.reg_alu9_en, bus.reg_alu12_en, bus.busy, m_alu12);
            end
        end
        step = 1'b1;
        tick();
        n_cmp++;
        if (m_alu12 !== 32'd1) begin
            n_err++;
            $display("FAIL step_resume: alu12 got %0d want 1", m_alu12);
        end
        tick();
        tick();
        tick();
        exp_runs++;
        n_cmp++;
        if (m_result !== 32'd32 || m_done !== 1'b1 || bus.run_count !== 8'(exp_runs)) begin
            n_err++;
            $display("FAIL step_result: result=%0d done=%b count=%0d want 32 1 %0d",
                     m_result, m_done, bus.run_count, exp_runs);
        end
        tick();
    endtask
`endif

    initial begin
        test_reset();
        set_in(3, 4, 10, 2, 5, 6, 7, 5);
        test_single(7, 8, 30, 37, 1, 37, 32, 32);
        set_in(3, 4, 10, 2, 5, 6, 3, 255);
        test_single(7, 8, 30, 37, 5, 185, 70, 70);
        test_back_to_back();
        test_reset_mid_run();
        test_count_wrap();
`ifdef SCHED_STEP_EN
        test_step();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
